// File: rtl/controle_rpn.sv
// RPN operand-stack sequencer: pushes switch values onto a small stack, issues
// binary operations to an external ALU and folds the result back onto the stack.
module controle_rpn #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                                  CLOCK,
    input  logic                                  RESET,
    input  logic                                  pulso_enter,
    input  logic                                  pulso_executar,
    input  logic                                  pulso_limpar,
    input  logic [LARGURA-1:0]                    chaves,
    input  logic [2:0]                            seletor_op,
    input  logic [LARGURA-1:0]                    ula_resultado,
    input  logic                                  ula_pronto,
    output logic [LARGURA-1:0]                    operando_a,
    output logic [LARGURA-1:0]                    operando_b,
    output logic [2:0]                            codigo_op,
    output logic                                  ula_valido,
    output logic [LARGURA-1:0]                    topo,
    output logic [$clog2(PROFUNDIDADE+1)-1:0]     profundidade,
    output logic                                  erro,
    output logic                                  ocupado,
    output logic [1:0]                            estado
);

    localparam int PW = $clog2(PROFUNDIDADE + 1);
    localparam int IW = $clog2(PROFUNDIDADE);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {OCIOSO, EMITE, AGUARDA, GRAVA} estado_t;

    estado_t              estado_atual, estado_prox;
    logic [LARGURA-1:0]   pilha [PROFUNDIDADE];
    logic [LARGURA-1:0]   resultado;
    logic [CW-1:0]        contador;
    logic                 faz_push, faz_emite, faz_captura, faz_grava, marca_erro;
    logic [IW-1:0]        idx_push, idx_topo, idx_segundo;

    assign idx_push    = IW'(profundidade);
    assign idx_topo    = IW'(profundidade - PW'(1));
    assign idx_segundo = IW'(profundidade - PW'(2));

    // ALU handshake: ula_valido is a one-cycle issue strobe with operands held
    // stable afterwards; ula_pronto is the ALU's single-cycle answer, only
    // honoured while waiting, so stale answers after a clear are dropped.
    assign ula_valido = (estado_atual == EMITE) && !pulso_limpar;
    assign ocupado    = (estado_atual != OCIOSO);
    assign estado     = estado_atual;
    assign topo       = (profundidade == '0) ? '0 : pilha[idx_topo];

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) estado_atual <= OCIOSO;
        else        estado_atual <= estado_prox;
    end

    always_comb begin
        estado_prox = estado_atual;
        faz_push    = 1'b0;
        faz_emite   = 1'b0;
        faz_captura = 1'b0;
        faz_grava   = 1'b0;
        marca_erro  = 1'b0;
        if (pulso_limpar) begin
            estado_prox = OCIOSO;
        end else begin
            case (estado_atual)
                OCIOSO: begin
                    if (pulso_executar) begin
                        if (profundidade >= PW'(2)) begin
                            faz_emite   = 1'b1;
                            estado_prox = EMITE;
                        end else begin
                            marca_erro = 1'b1;
                        end
                    end else if (pulso_enter) begin
                        if (profundidade < PW'(PROFUNDIDADE)) faz_push   = 1'b1;
                        else                                  marca_erro = 1'b1;
                    end
                end
                EMITE: estado_prox = AGUARDA;
                AGUARDA: begin
                    if (ula_pronto) begin
                        faz_captura = 1'b1;
                        estado_prox = GRAVA;
                    end else if (contador == CW'(TIMEOUT - 1)) begin
                        marca_erro  = 1'b1;
                        estado_prox = OCIOSO;
                    end
                end
                GRAVA: begin
                    faz_grava   = 1'b1;
                    estado_prox = OCIOSO;
                end
                default: estado_prox = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < PROFUNDIDADE; i++) pilha[i] <= '0;
            profundidade <= '0;
            erro         <= 1'b0;
            operando_a   <= '0;
            operando_b   <= '0;
            codigo_op    <= '0;
            resultado    <= '0;
            contador     <= '0;
        end else if (pulso_limpar) begin
            for (int i = 0; i < PROFUNDIDADE; i++) pilha[i] <= '0;
            profundidade <= '0;
            erro         <= 1'b0;
            operando_a   <= '0;
            operando_b   <= '0;
            codigo_op    <= '0;
            resultado    <= '0;
            contador     <= '0;
        end else begin
            if (estado_atual != AGUARDA) contador <= '0;
            else if (!ula_pronto)        contador <= contador + CW'(1);
            if (faz_push) begin
                pilha[idx_push] <= chaves;
                profundidade    <= profundidade + PW'(1);
            end
            if (faz_emite) begin
                operando_a <= pilha[idx_segundo];
                operando_b <= pilha[idx_topo];
                codigo_op  <= seletor_op;
            end
            if (faz_captura) resultado <= ula_resultado;
            // Depth cannot change while an operation is in flight, so these
            // indices still point at the two operands that were issued.
            if (faz_grava) begin
                pilha[idx_segundo] <= resultado;
                pilha[idx_topo]    <= '0;
                profundidade       <= profundidade - PW'(1);
            end
            if (marca_erro) erro <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controle_rpn.sv
// Directed plus randomised bench for controle_rpn with a reference stack model
// and an ALU-result scoreboard queue.
module tb_controle_rpn;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       pulso_enter, pulso_executar, pulso_limpar;
    logic [7:0] chaves;
    logic [2:0] seletor_op;
    logic [7:0] ula_resultado;
    logic       ula_pronto;
    logic [7:0] operando_a, operando_b, topo;
    logic [2:0] codigo_op, profundidade;
    logic       ula_valido, erro, ocupado;
    logic [1:0] estado;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    logic [7:0] mstk [4];
    int         mprof;
    logic       merr;

    controle_rpn dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .pulso_enter(pulso_enter), .pulso_executar(pulso_executar), .pulso_limpar(pulso_limpar),
        .chaves(chaves), .seletor_op(seletor_op),
        .ula_resultado(ula_resultado), .ula_pronto(ula_pronto),
        .operando_a(operando_a), .operando_b(operando_b), .codigo_op(codigo_op),
        .ula_valido(ula_valido), .topo(topo), .profundidade(profundidade),
        .erro(erro), .ocupado(ocupado), .estado(estado)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [7:0] model_topo();
        return (mprof == 0) ? 8'h00 : mstk[mprof-1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check_stack(input string tag);
        check({tag, "_topo"}, 32'(topo), 32'(model_topo()));
        check({tag, "_prof"}, 32'(profundidade), 32'(mprof));
        check({tag, "_erro"}, 32'(erro), 32'(merr));
    endtask

    task automatic push(input logic [7:0] v);
        chaves = v;
        pulso_enter = 1'b1;
        step();
        pulso_enter = 1'b0;
        if (mprof < 4) begin
            mstk[mprof] = v;
            mprof++;
        end else begin
            merr = 1'b1;
        end
    endtask

    task automatic limpar();
        pulso_limpar = 1'b1;
        step();
        pulso_limpar = 1'b0;
        for (int i = 0; i < 4; i++) mstk[i] = 8'h00;
        mprof = 0;
        merr  = 1'b0;
    endtask

    // Issue an operation; the ALU answers after lat extra cycles of waiting.
    task automatic run_exec(input logic [2:0] op, input int lat, input string tag);
        logic [7:0] a, b;
        a = mstk[mprof-2];
        b = mstk[mprof-1];
        exp_q.push_back(alu_ref(a, b, op));
        seletor_op = op;
        pulso_executar = 1'b1;
        step();
        pulso_executar = 1'b0;
        check({tag, "_valido"}, 32'(ula_valido), 32'd1);
        check({tag, "_op_a"}, 32'(operando_a), 32'(a));
        check({tag, "_op_b"}, 32'(operando_b), 32'(b));
        check({tag, "_codigo"}, 32'(codigo_op), 32'(op));
        step();
        check({tag, "_valido_1ciclo"}, 32'(ula_valido), 32'd0);
        repeat (lat) step();
        check({tag, "_ocupado"}, 32'(ocupado), 32'd1);
        ula_resultado = alu_ref(a, b, op);
        ula_pronto = 1'b1;
        step();
        ula_pronto = 1'b0;
        ula_resultado = 8'h00;
        step();
        mstk[mprof-2] = exp_q[0];
        mstk[mprof-1] = 8'h00;
        mprof--;
        check({tag, "_resultado"}, 32'(topo), 32'(exp_q.pop_front()));
        check({tag, "_ocioso"}, 32'(ocupado), 32'd0);
        check_stack(tag);
    endtask

    initial begin
        RESET = 1'b0;
        pulso_enter = 1'b0; pulso_executar = 1'b0; pulso_limpar = 1'b0;
        chaves = 8'h00; seletor_op = 3'd0; ula_resultado = 8'h00; ula_pronto = 1'b0;
        for (int i = 0; i < 4; i++) mstk[i] = 8'h00;
        mprof = 0;
        merr  = 1'b0;
        repeat (3) @(posedge CLOCK);
        #3;
        RESET = 1'b1;
        step();
        check_stack("reset");
        check("reset_ocupado", 32'(ocupado), 32'd0);
        check("reset_valido", 32'(ula_valido), 32'd0);
        check("reset_op_a", 32'(operando_a), 32'd0);
        check("reset_op_b", 32'(operando_b), 32'd0);
        check("reset_codigo", 32'(codigo_op), 32'd0);

        // Push and overflow
        push(8'h05);
        push(8'h03);
        check_stack("push2");
        push(8'h11);
        push(8'h22);
        check_stack("push4");
        push(8'h33);
        check_stack("overflow");
        check("overflow_topo_fixo", 32'(topo), 32'h22);
        limpar();
        check_stack("limpar");

        // Basic execute with minimum latency
        push(8'h05);
        push(8'h03);
        run_exec(3'd1, 0, "exec_add");
        check("exec_add_topo08", 32'(topo), 32'h08);

        // Error flag does not block operations and is sticky
        push(8'h33);
        push(8'h44);
        push(8'h55);
        push(8'h66);
        check_stack("overflow2");
        run_exec(3'd2, 3, "exec_sub_err");
        run_exec(3'd3, 15, "exec_pronto_ultimo");

        // Randomised operation chains
        for (int it = 0; it < 4; it++) begin
            limpar();
            repeat ($urandom_range(2, 4)) push(8'($urandom_range(0, 255)));
            check_stack("rnd_push");
            while (mprof >= 2)
                run_exec(3'($urandom_range(1, 5)), $urandom_range(0, 6), "rnd_exec");
        end

        // Underflow
        limpar();
        push(8'h42);
        pulso_executar = 1'b1;
        seletor_op = 3'd1;
        step();
        pulso_executar = 1'b0;
        merr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("underflow_valido", 32'(ula_valido), 32'd0);
            check("underflow_ocupado", 32'(ocupado), 32'd0);
            step();
        end
        check_stack("underflow");

        // Enter/executar collision, then an enter during the wait
        limpar();
        push(8'h10);
        push(8'h07);
        chaves = 8'h77;
        seletor_op = 3'd2;
        pulso_enter = 1'b1;
        pulso_executar = 1'b1;
        step();
        pulso_enter = 1'b0;
        pulso_executar = 1'b0;
        check("colisao_valido", 32'(ula_valido), 32'd1);
        check("colisao_prof", 32'(profundidade), 32'd2);
        step();
        chaves = 8'h99;
        pulso_enter = 1'b1;
        step();
        pulso_enter = 1'b0;
        check("aguarda_enter_prof", 32'(profundidade), 32'd2);
        exp_q.push_back(alu_ref(8'h10, 8'h07, 3'd2));
        ula_resultado = 8'h09;
        ula_pronto = 1'b1;
        step();
        ula_pronto = 1'b0;
        step();
        mstk[0] = 8'h09; mstk[1] = 8'h00; mprof = 1;
        check("colisao_resultado", 32'(topo), 32'(exp_q.pop_front()));
        check_stack("colisao");

        // Timeout: no pronto ever
        push(8'h21);
        seletor_op = 3'd1;
        pulso_executar = 1'b1;
        step();
        pulso_executar = 1'b0;
        repeat (16) step();
        check("timeout_k17_ocupado", 32'(ocupado), 32'd1);
        check("timeout_k17_erro", 32'(erro), 32'd0);
        step();
        merr = 1'b1;
        check("timeout_k18_ocupado", 32'(ocupado), 32'd0);
        check_stack("timeout");

        // Clear during wait; late pronto ignored
        pulso_executar = 1'b1;
        step();
        pulso_executar = 1'b0;
        step();
        limpar();
        check_stack("limpar_aguarda");
        check("limpar_aguarda_ocupado", 32'(ocupado), 32'd0);
        ula_resultado = 8'hAA;
        ula_pronto = 1'b1;
        step();
        ula_pronto = 1'b0;
        step();
        check_stack("pronto_tardio");
        check("pronto_tardio_ocupado", 32'(ocupado), 32'd0);

        // Asynchronous reset during GRAVA
        push(8'h0C);
        push(8'h0D);
        pulso_executar = 1'b1;
        step();
        pulso_executar = 1'b0;
        step();
        ula_resultado = 8'h55;
        ula_pronto = 1'b1;
        step();
        ula_pronto = 1'b0;
        check("grava_ocupado", 32'(ocupado), 32'd1);
        #2 RESET = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mstk[i] = 8'h00;
        mprof = 0;
        merr = 1'b0;
        check_stack("reset_async");
        check("reset_async_ocupado", 32'(ocupado), 32'd0);
        check("reset_async_op_a", 32'(operando_a), 32'd0);
        check("reset_async_op_b", 32'(operando_b), 32'd0);
        @(negedge CLOCK);
        RESET = 1'b1;
        step();
        check("pos_reset_ocupado", 32'(ocupado), 32'd0);
        check_stack("pos_reset");
        check("scoreboard_vazio", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
